uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_defs.sv | 18 +
 rtl/bit_sync.sv | 30 +++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions, used by the receiver and the future transmitter.
//   UART_DATA_BITS       : data bits per frame (8N1)
//   DEFAULT_CLKS_PER_BIT : 100 MHz / 115200 baud
//   uart_state_e         : serial FSM state encodings
package uart_defs;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset; both flops load ResetVal
//   d_i    : asynchronous input
//   q_o    : synchronized output
module bit_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   UART_RX   : asynchronous serial input, idles high, LSB first
//   rx_data   : received byte, valid while rx_valid is high
//   rx_valid  : holding register full
//   rx_ready  : consumer accepts on rx_valid && rx_ready at a clock edge
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, completed byte dropped (holding register full)
module uart_rx
  import uart_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      UART_RX,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  IdxLast  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  bit_sync #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (UART_RX),
    .q_o   (rx_s)
  );

  uart_state_e               state_q;
  logic [15:0]               cnt_q;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;

  logic half_tick;
  logic bit_tick;
  logic deliver;

  always_comb begin
    half_tick = (cnt_q == HalfLast);
    bit_tick  = (cnt_q == BitLast);
    // A good stop bit completes a byte this cycle.
    deliver   = (state_q == StStop) && bit_tick && rx_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        StStart: begin
          if (half_tick) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        // Samples land mid-bit since the count starts from mid start bit.
        StData: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == IdxLast) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        StStop: begin
          if (bit_tick) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        // Line held low after a bad stop: wait for it to return to idle.
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase

      // Holding register: a same-cycle accept frees the slot for the new byte.
      if (deliver) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       line     = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .UART_RX  (line),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Frame timing is computed from the edge at which the synchronized line
  // is first seen low: start check at +HALF, bit k sample at +HALF+k*CPB.
  typedef enum {MIdle, MFrame, MBreak} mmode_e;
  mmode_e     m_mode  = MIdle;
  int         m_n     = 0;
  int         m_n0    = 0;
  logic [7:0] m_byte  = '0;
  logic       m_hist[$];
  logic       e_valid = 1'b0;
  logic [7:0] e_data  = '0;
  logic       e_fe    = 1'b0;
  logic       e_ov    = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hist.delete();
      m_mode  = MIdle;
      m_n     = 0;
      m_byte  = '0;
      e_valid = 1'b0;
      e_data  = '0;
      e_fe    = 1'b0;
      e_ov    = 1'b0;
    end else begin
      logic seen, dlv, fe, ov;
      int   off, k;
      dlv = 1'b0; fe = 1'b0; ov = 1'b0;
      m_hist.push_back(line);
      // Line value two clock edges old; before that the synchronizer reads 1.
      seen = (m_hist.size() >= 3) ? m_hist[m_hist.size()-3] : 1'b1;
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      m_n++;
      case (m_mode)
        MIdle: if (!seen) begin m_n0 = m_n; m_mode = MFrame; end
        MFrame: begin
          off = m_n - m_n0;
          if (off == HALF) begin
            if (seen) m_mode = MIdle;
          end else if (off > HALF && ((off - HALF) % CPB) == 0) begin
            k = (off - HALF) / CPB;
            if (k <= 8) begin
              m_byte[3'(k-1)] = seen;
            end else if (seen) begin
              dlv = 1'b1; m_mode = MIdle;
            end else begin
              fe = 1'b1; m_mode = MBreak;
            end
          end
        end
        MBreak: if (seen) m_mode = MIdle;
        default: m_mode = MIdle;
      endcase
      if (dlv) begin
        if (e_valid && !rx_ready) ov = 1'b1;
        else begin e_data = m_byte; e_valid = 1'b1; end
      end else if (e_valid && rx_ready) begin
        e_valid = 1'b0;
      end
      e_fe = fe;
      e_ov = ov;
    end
  end

  // ---------------- per-cycle compare + event monitor ----------------
  logic       pv = 1'b0;
  logic [7:0] dut_bytes[$];
  int         n_fe = 0;
  int         n_ov = 0;

  always @(posedge clk) begin
    logic rdy_e;
    rdy_e = rx_ready;
    #1;
    check("rx_valid", rx_valid, e_valid);
    check("frame_err", frame_err, e_fe);
    check("overrun", overrun, e_ov);
    if (e_valid) check("rx_data", rx_data, e_data);
    if (reset) begin
      if (rx_valid && (!pv || rdy_e)) dut_bytes.push_back(rx_data);
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
    end
    pv = rx_valid;
  end

  // ---------------- stimulus ----------------
  logic rand_rdy = 1'b0;
  always @(negedge clk) if (rand_rdy) rx_ready = ($urandom_range(0, 3) != 0);

  task automatic send(input logic [7:0] b, input logic stop);
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (CPB) @(negedge clk);
    end
    line = stop;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int base, fe0, ov0, lat;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 with rx_ready=1; latency = 2 sync + HALF + 9*CPB + 1 register
    rx_ready = 1'b1;
    base = dut_bytes.size(); fe0 = n_fe; ov0 = n_ov; lat = 0;
    fork
      send(8'hA5, 1'b1);
      begin
        while (!rx_valid && lat < 400) begin @(negedge clk); lat++; end
      end
    join
    repeat (10) @(negedge clk);
    check("a5 latency", lat, 155);
    check("a5 count", dut_bytes.size() - base, 1);
    if (dut_bytes.size() > base) check("a5 data", dut_bytes[base], 8'hA5);
    check("a5 frame_err", n_fe - fe0, 0);
    check("a5 overrun", n_ov - ov0, 0);

    // 5-cycle low glitch, then 0x5A
    base = dut_bytes.size(); fe0 = n_fe;
    line = 1'b0; repeat (5) @(negedge clk); line = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch no byte", dut_bytes.size() - base, 0);
    check("glitch no frame_err", n_fe - fe0, 0);
    send(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("5a count", dut_bytes.size() - base, 1);
    if (dut_bytes.size() > base) check("5a data", dut_bytes[base], 8'h5A);

    // 0x3C with low stop, break, then 0x81
    base = dut_bytes.size(); fe0 = n_fe;
    send(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    line = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    check("3c frame_err pulses", n_fe - fe0, 1);
    check("81 count", dut_bytes.size() - base, 1);
    if (dut_bytes.size() > base) check("81 data", dut_bytes[base], 8'h81);

    // Overrun: hold 0x11, drop 0x22
    rx_ready = 1'b0; ov0 = n_ov;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check("ovr pulses", n_ov - ov0, 1);
    check("ovr held valid", rx_valid, 1);
    check("ovr held data", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("ovr accepted", rx_valid, 0);

    // Reset during DATA of 0xFF, then 0x0F
    base = dut_bytes.size(); rx_ready = 1'b1;
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset rx_valid", rx_valid, 0);
        check("midreset rx_data", rx_data, 0);
        check("midreset flags", {frame_err, overrun}, 0);
        reset = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    send(8'h0F, 1'b1);
    repeat (20) @(negedge clk);
    check("0f count", dut_bytes.size() - base, 1);
    if (dut_bytes.size() > base) check("0f data", dut_bytes[base], 8'h0F);

    // Back-to-back 0x00, 0xFF; accept exactly in the 0xFF delivery cycle
    rx_ready = 1'b0; base = dut_bytes.size(); ov0 = n_ov;
    fork
      begin send(8'h00, 1'b1); send(8'hFF, 1'b1); end
      begin
        repeat (314) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("b2b overrun", n_ov - ov0, 0);
    check("b2b valid", rx_valid, 1);
    check("b2b data", rx_data, 8'hFF);
    check("b2b count", dut_bytes.size() - base, 2);
    if (dut_bytes.size() > base + 1) begin
      check("b2b first", dut_bytes[base], 8'h00);
      check("b2b second", dut_bytes[base+1], 8'hFF);
    end
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized traffic: frames, glitches, bad stops, random gaps and ready
    rand_rdy = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        line = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        line = 1'b1;
      end else if (kind == 1) begin
        send(8'($urandom), 1'b0);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        line = 1'b1;
      end else begin
        send(8'($urandom), 1'b1);
      end
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    line = 1'b1;
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
